// File: rtl/fp_fetch_pkg.sv
// fp_fetch_pkg: shared FSM state encoding and operand address offsets for the FP operand fetch path
package fp_fetch_pkg;
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH_A  = 3'd1,
    FETCH_B  = 3'd2,
    CAP_B    = 3'd3,
    ISSUE    = 3'd4,
    WAIT_RES = 3'd5
  } state_t;
  localparam int unsigned A_OFS = 0;
  localparam int unsigned B_OFS = 1;
endpackage

// File: rtl/en_sync_edge.sv
// en_sync_edge: two-flop synchronizer plus rising-edge detector for an asynchronous level input
// Ports: clk, rst (async, active-high), en (async level), sync (synchronized level), rise (one-cycle edge pulse)
module en_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic sync,
  output logic rise
);
  logic s1, s2, s3;
  always_ff @(posedge clk or posedge rst)
    if (rst) {s1, s2, s3} <= 3'b000;
    else {s1, s2, s3} <= {en, s1, s2};
  assign sync = s2;
  assign rise = s2 & ~s3;
endmodule

// File: rtl/fp_operand_fetch.sv
// fp_operand_fetch: per-press operand pair fetch from sync memory, valid/ready issue to the FP adder, result capture
// Ports: clk, rst (async, active-high), en (async request), mem_addr/mem_rd/mem_data (operand memory, 1-cycle read),
//        op_a/op_b/op_valid/op_ready (adder operand handshake), res_valid/res_data (adder result strobe),
//        result (last captured result), entry_idx (current/next entry), busy (not IDLE), done_pulse (last entry captured)
// Build option: FP_FETCH_AUTO_RUN_EN keeps fetching the next entry while the synchronized en stays high.
module fp_operand_fetch
  import fp_fetch_pkg::*;
#(
  parameter int NUM    = 10,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int IDX_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] op_a,
  output logic [DATA_W-1:0] op_b,
  output logic              op_valid,
  input  logic              op_ready,
  input  logic              res_valid,
  input  logic [DATA_W-1:0] res_data,
  output logic [DATA_W-1:0] result,
  output logic [IDX_W-1:0]  entry_idx,
  output logic              busy,
  output logic              done_pulse
);
`ifdef FP_FETCH_AUTO_RUN_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif
  state_t state, nxt;
  logic s2, rise, cap, last;
  logic [IDX_W-1:0] idx;
  logic [ADDR_W-1:0] base;
  en_sync_edge u_sync (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .sync (s2),
    .rise (rise)
  );
  assign base = ADDR_W'({idx, 1'b0});
  assign last = idx == IDX_W'(NUM - 1);
  assign cap = state == WAIT_RES && res_valid;
  assign op_valid = state == ISSUE;
  assign busy = state != IDLE;
  assign entry_idx = idx;
  always_comb begin
    mem_rd = state == FETCH_A || state == FETCH_B;
    mem_addr = state == FETCH_A ? base + ADDR_W'(A_OFS) : state == FETCH_B ? base + ADDR_W'(B_OFS) : '0;
    nxt = state;
    case (state)
      IDLE:     nxt = rise ? FETCH_A : IDLE;
      FETCH_A:  nxt = FETCH_B;
      FETCH_B:  nxt = CAP_B;
      CAP_B:    nxt = ISSUE;
      ISSUE:    nxt = op_ready ? WAIT_RES : ISSUE;
      WAIT_RES: nxt = !res_valid ? WAIT_RES : (AUTO && s2) ? FETCH_A : IDLE;
      default:  nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      idx <= '0;
      op_a <= '0;
      op_b <= '0;
      result <= '0;
      done_pulse <= 1'b0;
    end else begin
      state <= nxt;
      done_pulse <= cap && last;
      if (state == FETCH_B) op_a <= mem_data;
      if (state == CAP_B) op_b <= mem_data;
      if (cap) begin
        result <= res_data;
        idx <= last ? '0 : idx + IDX_W'(1);
      end
    end
endmodule

// File: tb/tb_fp_operand_fetch.sv
// tb_fp_operand_fetch: randomized scoreboard bench with memory/adder models for fp_operand_fetch
module tb_fp_operand_fetch;
  localparam int NUM = 10;
  typedef struct {
    logic [3:0]  idx;
    logic        done;
    logic [31:0] res;
  } exp_t;
  logic clk = 0, rst = 1, en = 0;
  logic [4:0] mem_addr;
  logic mem_rd, op_valid, op_ready, res_valid, busy, done_pulse;
  logic [31:0] mem_data = 0, op_a, op_b, res_data, result;
  logic [3:0] entry_idx;
  logic [31:0] mem [32];
  logic [4:0] addr_q[$];
  logic [63:0] op_q[$];
  exp_t exp_q[$];
  int n_cmp = 0, n_err = 0, midx = 0, stall = 0;
  fp_operand_fetch dut (
    .clk(clk), .rst(rst), .en(en), .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data),
    .op_a(op_a), .op_b(op_b), .op_valid(op_valid), .op_ready(op_ready), .res_valid(res_valid),
    .res_data(res_data), .result(result), .entry_idx(entry_idx), .busy(busy), .done_pulse(done_pulse)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (mem_rd) mem_data <= mem[mem_addr];
  function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
    return (a == 32'h3F800000 && b == 32'h40000000) ? 32'h40400000 : a ^ {b[15:0], b[31:16]} ^ 32'h13579BDF;
  endfunction
  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endfunction
  function automatic void miss(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got unexpected DUT event expected none", nm);
  endfunction
  function automatic void expect_op();
    addr_q.push_back(5'(2 * midx));
    addr_q.push_back(5'(2 * midx + 1));
    op_q.push_back({mem[2*midx], mem[2*midx+1]});
    exp_q.push_back('{idx: 4'((midx + 1) % NUM), done: midx == NUM - 1, res: fadd(mem[2*midx], mem[2*midx+1])});
    midx = (midx + 1) % NUM;
  endfunction
  // adder model: optional stall, optional same-cycle bogus result, random result latency, stray strobes when idle
  initial begin
    logic pend;
    int lat;
    logic [31:0] aa, bb;
    pend = 0; lat = 0; aa = 0; bb = 0;
    op_ready = 0; res_valid = 0; res_data = 0;
    forever begin
      @(posedge clk); #1;
      if (rst) begin
        op_ready = 0; res_valid = 0; pend = 0;
      end else begin
        if (op_ready) begin pend = 1; lat = $urandom_range(0, 4); end
        op_ready = 0; res_valid = 0;
        if (pend) begin
          if (lat == 0) begin res_valid = 1; res_data = fadd(aa, bb); pend = 0; end
          else lat--;
        end else if (op_valid) begin
          if (stall > 0) stall--;
          else begin
            op_ready = 1; aa = op_a; bb = op_b;
            if ($urandom_range(0, 2) == 0) begin res_valid = 1; res_data = $urandom; end
          end
        end else if ($urandom_range(0, 3) == 0) begin
          res_valid = 1; res_data = $urandom;
        end
      end
    end
  end
  // monitor: pops expectations whenever the DUT reads memory, hands off operands or captures a result
  logic [3:0] last_idx = 0;
  logic pv = 0, pr = 0;
  logic [63:0] pab = 0;
  always @(negedge clk) begin
    if (rst) begin
      last_idx = entry_idx; pv = 0; pr = 0;
    end else begin
      if (mem_rd) begin
        if (addr_q.size() == 0) miss("mem_addr");
        else chk("mem_addr", 64'(mem_addr), 64'(addr_q.pop_front()));
      end
      if (pv && !pr && op_valid) chk("op_stable", {op_a, op_b}, pab);
      if (op_valid && op_ready) begin
        if (op_q.size() == 0) miss("op_accept");
        else chk("op_ab", {op_a, op_b}, op_q.pop_front());
      end
      if (entry_idx != last_idx || done_pulse) begin
        if (exp_q.size() == 0) miss("capture");
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("entry_idx", 64'(entry_idx), 64'(e.idx));
          chk("done_pulse", 64'(done_pulse), 64'(e.done));
          chk("result", 64'(result), 64'(e.res));
        end
      end
      last_idx = entry_idx; pv = op_valid; pr = op_ready; pab = {op_a, op_b};
    end
  end
  task automatic press(input int st, input bit tog);
    int cyc, first;
    bit seen;
    cyc = 0; first = 0; seen = 0;
    expect_op();
    stall = st;
    @(negedge clk); en = 1;
    while (cyc < 300) begin
      @(negedge clk); cyc++;
      if (op_valid && first == 0) first = cyc;
      if (busy) begin
        seen = 1;
        if (!tog) en = 0;
        else if (cyc == 9) en = 0;
        else if (cyc == 13) en = 1;
      end else if (seen) break;
    end
    chk("op_valid_latency", 64'(first), 64'd6);
    chk("op_complete", 64'(seen && !busy), 64'd1);
    en = 0;
    repeat (5) @(negedge clk);
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    mem[0] = 32'h3F800000;
    mem[1] = 32'h40000000;
    repeat (2) @(negedge clk);
    chk("rst_op_valid", 64'(op_valid), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_result", 64'(result), 0);
    chk("rst_entry_idx", 64'(entry_idx), 0);
    chk("rst_done", 64'(done_pulse), 0);
    chk("rst_mem_rd", 64'(mem_rd), 0);
    chk("rst_op_ab", {op_a, op_b}, 0);
    rst = 0;
    repeat (3) @(negedge clk);
    press(0, 0);
    chk("first_result", 64'(result), 64'h40400000);
    press(4, 0);
    press(12, 1);
    chk("idx_after_toggle", 64'(entry_idx), 64'd3);
    for (int i = 0; i < 9; i++) press($urandom_range(0, 3), 0);
    chk("idx_after_wrap", 64'(entry_idx), 64'd2);
    begin
      int w;
      w = 0;
      expect_op();
      stall = 40;
      @(negedge clk); en = 1;
      while (!op_valid && w < 20) begin @(negedge clk); w++; end
      en = 0;
      chk("issue_reached", 64'(op_valid), 64'd1);
      repeat (3) @(negedge clk);
      #1 rst = 1;
      #1;
      chk("mid_rst_op_valid", 64'(op_valid), 0);
      chk("mid_rst_busy", 64'(busy), 0);
      chk("mid_rst_result", 64'(result), 0);
      chk("mid_rst_entry_idx", 64'(entry_idx), 0);
      chk("mid_rst_addr_q", 64'(addr_q.size()), 0);
      op_q.delete(); exp_q.delete();
      midx = 0; stall = 0;
      repeat (2) @(negedge clk);
      rst = 0;
      repeat (3) @(negedge clk);
      chk("post_rst_busy", 64'(busy), 0);
    end
    press(1, 0);
    press(0, 0);
    chk("final_idx", 64'(entry_idx), 64'd2);
    chk("addr_q_empty", 64'(addr_q.size()), 0);
    chk("op_q_empty", 64'(op_q.size()), 0);
    chk("exp_q_empty", 64'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
